intensity_writer: RTL and testbench

- Downstream of the exposure control logic, upstream of the I2C controller driving the 7-bit digipot at address 0x2F.
- Accepts intensity requests in percent (0..100), clamps them and scales them to a 7-bit wiper code.
- Sequences the enable/ready handshake with the I2C controller: one write per transaction, latest request wins, enforced inter-write gap, start timeout with error flag.
- A safety zero input overrides everything and drives the wiper to code 0.

---
 rtl/intensity_writer_pkg.sv | 24 ++
 rtl/intensity_writer_if.sv | 13 +
 rtl/intensity_writer_pct_to_code.sv | 21 ++
 rtl/intensity_writer.sv | 134 +++++++++++++
 tb/tb_intensity_writer.sv | 369 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/intensity_writer_pkg.sv
// intensity_writer_pkg: shared types and constants for the digipot intensity writer.
package intensity_writer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_ISSUE,
    ST_WAIT_START,
    ST_WAIT_DONE,
    ST_GAP
  } state_t;

  localparam int          PCT_MAX_DEF  = 100;
  localparam logic [15:0] SCALE_MUL    = 16'd325;
  localparam logic [15:0] SCALE_RND    = 16'd128;
  localparam int          SCALE_SHIFT  = 8;
  localparam logic [6:0]  DIGIPOT_ADDR = 7'h2F;

  // Saturate a percent request at the ceiling.
  function automatic logic [7:0] clamp_pct(input logic [7:0] pct, input logic [7:0] ceil);
    return (pct > ceil) ? ceil : pct;
  endfunction

endpackage

// File: rtl/intensity_writer_if.sv
// intensity_writer_if: start/ready handshake toward the I2C controller.
// enable is a one-cycle start strobe carrying data/addr. The controller
// acknowledges the start by dropping ready and reports completion by
// raising ready again; a new start is only issued while ready is high.
interface intensity_writer_if;
  logic       enable;
  logic [7:0] data;
  logic [6:0] addr;
  logic       ready;

  modport master (output enable, output data, output addr, input ready);
  modport slave  (input enable, input data, input addr, output ready);
endinterface

// File: rtl/intensity_writer_pct_to_code.sv
// pct_to_code: combinational clamp of a percent value and scale to a 7-bit wiper code.
module pct_to_code
  import intensity_writer_pkg::*;
#(
  parameter int PCT_MAX = PCT_MAX_DEF
) (
  input  logic [7:0] pct,
  output logic [6:0] code
);

  logic [7:0]  p;
  logic [15:0] prod;

  // Round-to-nearest of p * 127/100 using a 325/256 fixed-point factor.
  always_comb begin
    p    = clamp_pct(pct, 8'(PCT_MAX));
    prod = 16'(p) * SCALE_MUL + SCALE_RND;
    code = 7'(prod >> SCALE_SHIFT);
  end

endmodule

// File: rtl/intensity_writer.sv
// intensity_writer: turns percent requests into single digipot writes over the
// I2C start/ready handshake, with latest-wins pending request, post-write gap,
// start timeout with retry, and a force_zero safety override.
// Build option: define INTENSITY_DEDUP_EN to skip writes whose code equals code_out.
module intensity_writer
  import intensity_writer_pkg::*;
#(
  parameter int PCT_MAX       = PCT_MAX_DEF,
  parameter int GAP_CYCLES    = 160,
  parameter int START_TIMEOUT = 1600
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [7:0]         pct_in,
  input  logic               pct_valid,
  input  logic               force_zero,
  intensity_writer_if.master i2c,
  output logic               busy,
  output logic [6:0]         code_out,
  output logic               err,
  output state_t             state_dbg
);

  localparam logic [15:0] TMO_LAST = 16'(START_TIMEOUT - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);
  localparam logic [7:0]  PCT_CEIL = 8'(PCT_MAX);

  state_t      state_q, state_d;
  logic        pending_q;
  logic [7:0]  pend_pct_q;
  logic        fz_q;
  logic [15:0] cnt_q;
  logic [7:0]  data_q;
  logic [6:0]  code_q;
  logic        err_q;

  logic [6:0]  calc_code;
  logic [6:0]  latch_code;
  logic        fz_rise;
  logic        timeout_hit;
  logic        gap_done;
  logic        skip;

  pct_to_code #(.PCT_MAX(PCT_MAX)) u_scale (
    .pct  (pend_pct_q),
    .code (calc_code)
  );

  assign latch_code  = force_zero ? 7'd0 : calc_code;
  assign fz_rise     = force_zero & ~fz_q;
  // A falling ready takes priority over the timeout in the same cycle.
  assign timeout_hit = (state_q == ST_WAIT_START) && i2c.ready && (cnt_q == TMO_LAST);
  assign gap_done    = (state_q == ST_GAP) && (cnt_q == GAP_LAST);

`ifdef INTENSITY_DEDUP_EN
  assign skip = (latch_code == code_q) && !force_zero;
`else
  assign skip = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:       if (pending_q && i2c.ready) state_d = ST_LATCH;
      ST_LATCH:      state_d = skip ? ST_IDLE : ST_ISSUE;
      ST_ISSUE:      state_d = ST_WAIT_START;
      ST_WAIT_START: begin
        if (!i2c.ready)       state_d = ST_WAIT_DONE;
        else if (timeout_hit) state_d = ST_GAP;
      end
      ST_WAIT_DONE:  if (i2c.ready) state_d = ST_GAP;
      ST_GAP:        if (gap_done) state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  // Moore outputs.
  always_comb begin
    i2c.enable = 1'b0;
    busy       = 1'b0;
    i2c.enable = (state_q == ST_ISSUE);
    busy       = (state_q != ST_IDLE) || pending_q;
  end

  // Request capture, timers, issued data and acknowledged code.
  // Later writes to pending_q override earlier ones: a strobe or force_zero
  // edge in the LATCH cycle stays pending for the next transaction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q  <= 1'b0;
      pend_pct_q <= '0;
      fz_q       <= 1'b0;
      cnt_q      <= '0;
      data_q     <= '0;
      code_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      fz_q  <= force_zero;
      err_q <= timeout_hit;
      if (state_q != state_d)
        cnt_q <= '0;
      else if (state_q == ST_WAIT_START || state_q == ST_GAP)
        cnt_q <= cnt_q + 16'd1;
      if (state_q == ST_LATCH) begin
        pending_q <= 1'b0;
        data_q    <= {1'b0, latch_code};
      end
      if (timeout_hit) pending_q <= 1'b1;
      if (pct_valid) begin
        pending_q  <= 1'b1;
        pend_pct_q <= clamp_pct(pct_in, PCT_CEIL);
      end
      if (fz_rise) begin
        pending_q  <= 1'b1;
        pend_pct_q <= '0;
      end
      if (state_q == ST_WAIT_DONE && i2c.ready) code_q <= data_q[6:0];
    end
  end

  assign i2c.data  = data_q;
  assign i2c.addr  = DIGIPOT_ADDR;
  assign code_out  = code_q;
  assign err       = err_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_intensity_writer.sv
// tb_intensity_writer: randomized bench with a transaction-level reference model
// for intensity_writer (scenario tests plus random requests).
module tb_intensity_writer;
  import intensity_writer_pkg::*;

  localparam int GAP = 160;
  localparam int TMO = 1600;
`ifdef INTENSITY_DEDUP_EN
  localparam bit DEDUP = 1'b1;
`else
  localparam bit DEDUP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] pct_in = 8'd0;
  logic       pct_valid = 1'b0;
  logic       force_zero = 1'b0;
  logic       busy;
  logic [6:0] code_out;
  logic       err;
  state_t     state_dbg;

  intensity_writer_if bus();

  intensity_writer #(.PCT_MAX(100), .GAP_CYCLES(GAP), .START_TIMEOUT(TMO)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pct_in     (pct_in),
    .pct_valid  (pct_valid),
    .force_zero (force_zero),
    .i2c        (bus),
    .busy       (busy),
    .code_out   (code_out),
    .err        (err),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #700000;
    $display("FAIL watchdog: actual=expired required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  logic [7:0] exp_q[$];
  logic [6:0] exp_code = 7'd0;
  bit         ack_flag = 1'b0;
  logic [6:0] ack_val = 7'd0;
  int         rst_count = 0;
  bit         slave_respond = 1'b1;
  bit         expect_timeout = 1'b0;
  int         err_count = 0;
  int         en_count = 0;
  bit         lat_armed = 1'b0;
  int         lat_strobe = 0;
  int         last_ack_cyc = -100000;
  int         last_err_cyc = -100000;
  int         last_en_cyc = -100000;
  bit         prev_en = 1'b0;
  bit         prev_err = 1'b0;
  logic [7:0] prev_data = 8'd0;

  task automatic check(input bit ok, input string name, input int act, input int exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference: clamp to 100 percent, scale to 0..127 rounding to nearest.
  function automatic int ref_code(input int pct);
    int p;
    p = (pct > 100) ? 100 : pct;
    return (p * 325 + 128) / 256;
  endfunction

  // ---------------- I2C controller model ----------------
  initial begin
    int         ep;
    logic [6:0] d;
    bus.ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (reset_n && bus.enable && slave_respond) begin
        ep = rst_count;
        d  = bus.data[6:0];
        repeat ($urandom_range(1, 4)) @(negedge clk);
        bus.ready = 1'b0;
        repeat ($urandom_range(4, 12)) @(negedge clk);
        bus.ready = 1'b1;
        if (ep == rst_count) begin
          ack_val  = d;
          ack_flag = 1'b1;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    logic [7:0] e;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (!reset_n) begin
        exp_code     = 7'd0;
        ack_flag     = 1'b0;
        prev_en      = 1'b0;
        prev_err     = 1'b0;
        prev_data    = bus.data;
        lat_armed    = 1'b0;
        last_ack_cyc = -100000;
        last_err_cyc = -100000;
      end else begin
        if (ack_flag) begin
          exp_code     = ack_val;
          ack_flag     = 1'b0;
          last_ack_cyc = cyc;
        end
        check(code_out == exp_code, "code_out", code_out, exp_code);
        if (bus.enable) begin
          en_count++;
          last_en_cyc = cyc;
          check(!prev_en, "enable_width", 2, 1);
          check(busy, "busy_during_write", busy, 1);
          check(bus.addr == 7'h2F, "addr", bus.addr, 47);
          check(exp_q.size() != 0, "unexpected_write", bus.data, -1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check(bus.data == e, "write_data", bus.data, e);
          end
          check(cyc - last_ack_cyc > GAP, "gap_after_done", cyc - last_ack_cyc, GAP + 1);
          check(cyc - last_err_cyc > GAP, "gap_after_timeout", cyc - last_err_cyc, GAP + 1);
          if (lat_armed) begin
            check(cyc - lat_strobe == 3, "latency", cyc - lat_strobe, 3);
            lat_armed = 1'b0;
          end
        end
`ifndef INTENSITY_DEDUP_EN
        if (bus.data != prev_data) check(bus.enable, "data_stable", bus.enable, 1);
`endif
        if (err) begin
          err_count++;
          check(!prev_err, "err_width", 2, 1);
          check(expect_timeout, "err_unexpected", 1, 0);
          check(cyc - last_en_cyc >= TMO && cyc - last_en_cyc <= TMO + 2,
                "timeout_delay", cyc - last_en_cyc, TMO + 1);
          last_err_cyc = cyc;
        end
        prev_en   = bus.enable;
        prev_err  = err;
        prev_data = bus.data;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic strobe(input int v);
    @(negedge clk);
    pct_in    = 8'(v);
    pct_valid = 1'b1;
    @(negedge clk);
    pct_valid = 1'b0;
  endtask

  task automatic push_exp(input int c);
    exp_q.push_back(8'(c));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    repeat (2) @(negedge clk);
    while ((busy || !bus.ready) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) check(1'b0, "idle_timeout", n, 3000);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_ready_low();
    int n;
    n = 0;
    @(posedge clk); #2;
    while (bus.ready && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    if (n >= 200) check(1'b0, "ready_low_timeout", n, 200);
  endtask

  task automatic wait_code(input int v);
    int n;
    n = 0;
    while (code_out != 7'(v) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) check(1'b0, "code_wait_timeout", code_out, v);
  endtask

  task automatic wait_err(input int target);
    int n;
    n = 0;
    while (err_count < target && n < 2500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2500) check(1'b0, "err_wait_timeout", err_count, target);
  endtask

  // Request while idle; the model decides whether a write must follow.
  task automatic issue_idle(input int v, output bit pushed);
    int c;
    c = ref_code(v);
    strobe(v);
    pushed = !(DEDUP && 7'(c) == exp_code);
    if (pushed) push_exp(c);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    bit pushed;
    int v, c, v2, c2, en0;

    repeat (3) @(negedge clk);
    check(bus.enable == 1'b0, "reset_enable", bus.enable, 0);
    check(bus.data == 8'd0, "reset_data", bus.data, 0);
    check(busy == 1'b0, "reset_busy", busy, 0);
    check(code_out == 7'd0, "reset_code_out", code_out, 0);
    check(err == 1'b0, "reset_err", err, 0);
    check(state_dbg == ST_IDLE, "reset_state", int'(state_dbg), 0);

    check(ref_code(0) == 0, "model_0", ref_code(0), 0);
    check(ref_code(1) == 1, "model_1", ref_code(1), 1);
    check(ref_code(50) == 63, "model_50", ref_code(50), 63);
    check(ref_code(75) == 95, "model_75", ref_code(75), 95);
    check(ref_code(100) == 127, "model_100", ref_code(100), 127);
    check(ref_code(200) == 127, "model_200", ref_code(200), 127);

    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // First request: 75 percent, fixed latency.
    @(negedge clk);
    pct_in     = 8'd75;
    pct_valid  = 1'b1;
    lat_strobe = cyc;
    lat_armed  = 1'b1;
    push_exp(95);
    @(negedge clk);
    pct_valid = 1'b0;
    check(busy == 1'b1, "busy_after_req", busy, 1);
    wait_idle();
    check(code_out == 7'd95, "t1_code_out", code_out, 95);

    // Clamp, then a request landing inside the gap.
    strobe(200);
    push_exp(127);
    wait_code(127);
    strobe(0);
    push_exp(0);
    wait_idle();
    check(code_out == 7'd0, "t2_code_out", code_out, 0);

    // Two strobes during a transaction: only the latest is written.
    strobe(20);
    push_exp(25);
    wait_ready_low();
    strobe(10);
    strobe(50);
    push_exp(63);
    wait_idle();
    check(code_out == 7'd63, "t3_code_out", code_out, 63);
    check(exp_q.size() == 0, "t3_queue_empty", exp_q.size(), 0);

    // Start timeout then retry of the same code.
    slave_respond  = 1'b0;
    expect_timeout = 1'b1;
    strobe(40);
    push_exp(51);
    push_exp(51);
    wait_err(1);
    slave_respond  = 1'b1;
    @(negedge clk);
    expect_timeout = 1'b0;
    wait_idle();
    check(err_count == 1, "t4_err_count", err_count, 1);
    check(code_out == 7'd51, "t4_code_out", code_out, 51);

    // force_zero overrides a pending 100 percent; its fall issues nothing.
    strobe(30);
    push_exp(38);
    wait_ready_low();
    strobe(100);
    @(negedge clk);
    force_zero = 1'b1;
    push_exp(0);
    wait_idle();
    check(code_out == 7'd0, "t5_code_out", code_out, 0);
    en0 = en_count;
    @(negedge clk);
    force_zero = 1'b0;
    repeat (60) @(negedge clk);
    check(en_count == en0, "t5_no_write_on_fall", en_count - en0, 0);
    check(busy == 1'b0, "t5_idle", busy, 0);

    // Repeated request.
    en0 = en_count;
    issue_idle(50, pushed);
    wait_idle();
    issue_idle(50, pushed);
    wait_idle();
    check(en_count - en0 == (DEDUP ? 1 : 2), "t6_repeat_writes", en_count - en0, DEDUP ? 1 : 2);

    // Reset in the middle of a write abandons it.
    strobe(90);
    push_exp(114);
    wait_ready_low();
    @(negedge clk);
    reset_n = 1'b0;
    rst_count++;
    exp_q.delete();
    @(negedge clk);
    check(bus.enable == 1'b0, "midrst_enable", bus.enable, 0);
    check(bus.data == 8'd0, "midrst_data", bus.data, 0);
    check(busy == 1'b0, "midrst_busy", busy, 0);
    check(code_out == 7'd0, "midrst_code_out", code_out, 0);
    @(negedge clk);
    reset_n = 1'b1;
    en0 = en_count;
    repeat (300) @(negedge clk);
    check(en_count == en0, "midrst_no_retry", en_count - en0, 0);
    check(busy == 1'b0, "midrst_idle", busy, 0);

    // Random requests, sometimes with a second strobe mid-transaction.
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      v = $urandom_range(0, 255);
      c = ref_code(v);
      issue_idle(v, pushed);
      if (pushed && $urandom_range(0, 1) == 1) begin
        wait_ready_low();
        v2 = $urandom_range(0, 255);
        c2 = ref_code(v2);
        strobe(v2);
        if (!(DEDUP && c2 == c)) push_exp(c2);
      end
      wait_idle();
    end

    check(exp_q.size() == 0, "final_queue_empty", exp_q.size(), 0);
    check(err_count == 1, "final_err_count", err_count, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
